// File: rtl/pwm_generator_if.sv
// PWM generator signal bundle: duty request in, waveform and period counter out.
interface pwm_generator_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] PWM_in;
  logic             PWM_out;
  logic [WIDTH-1:0] counter;

  modport master (output PWM_in, input PWM_out, input counter);
  modport slave  (input PWM_in, output PWM_out, output counter);
endinterface

// File: rtl/pwm_generator.sv
// Free-running 2^WIDTH-cycle PWM with registered output, one cycle behind the compare.
// Optional macro PWM_SHADOW_EN: duty is latched once per period at the wrap.
module pwm_generator #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_generator_if.slave  pwm
);

  logic [WIDTH-1:0] cnt_p0;
  logic             pwm_p1;
  logic [WIDTH-1:0] duty_eff;

  function automatic logic duty_hit(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] duty);
    return cnt < duty;
  endfunction

`ifdef PWM_SHADOW_EN
  logic [WIDTH-1:0] duty_shadow;

  // Loading on the last count makes the new duty cover the whole next period.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      duty_shadow <= '0;
    end else if (cnt_p0 == {WIDTH{1'b1}}) begin
      duty_shadow <= pwm.PWM_in;
    end
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = pwm.PWM_in;
`endif

  // p0: period counter; p1: registered compare result
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_p0 <= '0;
      pwm_p1 <= 1'b0;
    end else begin
      cnt_p0 <= cnt_p0 + {{(WIDTH-1){1'b0}}, 1'b1};
      pwm_p1 <= duty_hit(cnt_p0, duty_eff);
    end
  end

  assign pwm.counter = cnt_p0;
  assign pwm.PWM_out = pwm_p1;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: edge-count reference model plus directed period checks.
module tb_pwm_generator;

  localparam int W   = 8;
  localparam int PER = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  pwm_generator_if #(.WIDTH(W)) pif ();

  pwm_generator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm   (pif)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counter is edges since reset modulo the period; output is
  // whether the phase before the edge lay below the duty in force for that edge.
  int edges = 0;
  int shadow_m = 0;
  bit exp_pwm = 1'b0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      edges = 0;
      shadow_m = 0;
      exp_pwm = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      int phase;
      int duty;
      phase = edges % PER;
`ifdef PWM_SHADOW_EN
      duty = shadow_m;
`else
      duty = int'(pif.PWM_in);
`endif
      exp_pwm = (phase < duty);
      if (phase == PER - 1) shadow_m = int'(pif.PWM_in);
      edges++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_counter", int'(pif.counter), edges % PER);
      check("model_pwm_out", int'(pif.PWM_out), int'(exp_pwm));
    end
  end

  task automatic wait_cnt(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (int'(pif.counter) != target && guard < 3 * PER);
    if (guard >= 3 * PER) check("wait_timeout", int'(pif.counter), target);
  endtask

  // Counts high samples over one full period, compares 0..255 (samples counter 1..255,0).
  task automatic measure_period(output int highs, input int switch_at, input int new_val);
    highs = 0;
    wait_cnt(1);
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk);
      highs += int'(pif.PWM_out);
      if (switch_at >= 0 && int'(pif.counter) == switch_at) pif.PWM_in = W'(new_val);
    end
  endtask

  initial begin
    int h;
    rst_n = 1'b1;
    pif.PWM_in = 8'd100;

    // Reset with a nonzero duty request
    @(negedge clk);
    check("rst_counter", int'(pif.counter), 0);
    check("rst_pwm_out", int'(pif.PWM_out), 0);
    rst_n = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("count_after_release", int'(pif.counter), i);
    end

    // Wrap sequence
    wait_cnt(254);
    @(negedge clk); check("wrap_255", int'(pif.counter), 255);
    @(negedge clk); check("wrap_0",   int'(pif.counter), 0);
    @(negedge clk); check("wrap_1",   int'(pif.counter), 1);

    // Duty change at counter 100: 50 -> 200
    pif.PWM_in = 8'd50;
    measure_period(h, -1, 0);
    measure_period(h, -1, 0);
    check("duty50_period", h, 50);
    measure_period(h, 100, 200);
`ifdef PWM_SHADOW_EN
    check("switch_period_shadow", h, 50);
`else
    check("switch_period_direct", h, 150);
`endif
    measure_period(h, -1, 0);
    check("duty200_period", h, 200);

    // Mid-period reset while the output is high
    wait_cnt(128);
    check("pre_reset_pwm_high", int'(pif.PWM_out), 1);
    rst_n = 1'b1;
    pif.PWM_in = 8'd255;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_counter", int'(pif.counter), 0);
      check("midrst_pwm_out", int'(pif.PWM_out), 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("post_rst_counter", int'(pif.counter), 1);
`ifdef PWM_SHADOW_EN
    check("post_rst_pwm_shadow", int'(pif.PWM_out), 0);
`else
    check("post_rst_pwm_direct", int'(pif.PWM_out), 1);
`endif
    measure_period(h, -1, 0);
`ifdef PWM_SHADOW_EN
    check("first_period_shadow0", h, 0);
`else
    check("first_period_255", h, 255);
`endif

    // Duty sweep 0,5,...,255; second period after each step is fully at the new value
    for (int v = 0; v <= 255; v += 5) begin
      pif.PWM_in = W'(v);
      measure_period(h, -1, 0);
      measure_period(h, -1, 0);
      check($sformatf("sweep_duty_%0d", v), h, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
